regfile_rr_arbiter: RTL and testbench
=====================================

REGFILE_RR_ARBITER -- requirements
Module: regfile_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each register entry.
REQ-002 Parameter: DEPTH, default 4, number of register entries; address width is log2(DEPTH) (2 at default).
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req0, req1  input  1 each  Access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  Request type: 1 = write, 0 = read.
REQ-007 addr0, addr1  input  log2(DEPTH) each  Target entry.
REQ-008 wdata0, wdata1  input  WIDTH each  Write data.
REQ-009 gnt0, gnt1  output  1 each  One-cycle grant pulse to requester 0 / 1.
REQ-010 rdata  output  WIDTH  Read data, shared by both requesters.
REQ-011 rvalid  output  1  rdata valid, one-cycle pulse.
REQ-012 rsrc  output  1  Index of the requester that owns the current rdata.

Function
REQ-013 The block SHALL own DEPTH x WIDTH flip-flop storage, reachable only through the two request ports.
REQ-014 FSM SHALL have exactly two states, IDLE and ACCESS.
REQ-015 IDLE with no req asserted: stay in IDLE; gnt0 = gnt1 = 0.
REQ-016 IDLE with at least one req asserted: latch the winner's we, addr and wdata at that edge, then enter ACCESS.
REQ-017 ACCESS SHALL last exactly one cycle and then return to IDLE unconditionally; throughput is at most one access every 2 cycles.
REQ-018 In ACCESS, the winner's gnt SHALL be 1 and the other gnt SHALL be 0; gnt0 and gnt1 are never both 1.
REQ-019 Write in ACCESS: mem[addr] <= wdata at the edge that ends ACCESS; rvalid stays 0.
REQ-020 Read in ACCESS: rdata <= mem[addr], rvalid <= 1 and rsrc <= winner at the edge that ends ACCESS, so rvalid is high in the following IDLE cycle (read latency 2 cycles from the accepting edge).
REQ-021 rvalid SHALL be 1 for exactly one cycle per read; rdata SHALL hold its last value while rvalid = 0.
REQ-022 Round-robin pointer prio, 1 bit:
  - Both req high in IDLE: requester prio wins.
  - Exactly one req high: that requester wins, regardless of prio.
  - After any grant to requester X: prio <= 1 - X.
REQ-023 req, we, addr and wdata SHALL be ignored while in ACCESS.
REQ-024 A requester holds req until it sees gnt and drops req on the edge after gnt; a req still high in the next IDLE cycle is a new request.
REQ-025 Read-after-write: a read accepted after a write to the same address completes SHALL return the written data.
REQ-026 Back-to-back: with both requesters continuously requesting, grants SHALL alternate 0,1,0,1 in successive ACCESS cycles.
REQ-027 Out-of-range address (DEPTH not a power of 2): writes are dropped; reads return 0 with rvalid = 1.

Reset
REQ-028 When rst = 1 at an edge: state <= IDLE, prio <= 0, all storage <= 0, rdata <= 0, rvalid <= 0, rsrc <= 0; gnt0 = gnt1 = 0 in the following cycle.
REQ-029 rst asserted during ACCESS SHALL cancel that access: no write is performed and no rvalid is produced.
REQ-030 rst SHALL take priority over every request and state transition.

Verification
REQ-031 rst = 1 for 2 cycles, then read entry 0..3 via req0 -> each rvalid with rdata = 0x00, rsrc = 0.
REQ-032 req0 write addr 2 = 0xA5, then req1 read addr 2 -> gnt0 pulse, then gnt1 pulse; rvalid = 1, rdata = 0xA5, rsrc = 1 exactly 2 cycles after req1's accepting edge.
REQ-033 req0 and req1 both held high from reset (reads of addr 0, 1) -> gnt sequence 0,1,0,1 in alternating cycles; never both gnt high.
REQ-034 req1 alone high twice in a row (prio = 0) -> req1 granted both times; prio = 0 after each grant.
REQ-035 req0 write addr 3 = 0x3C accepted, rst = 1 during ACCESS; then read addr 3 -> rdata = 0x00.
REQ-036 req0 changes addr and wdata during ACCESS (0x11 -> 0x22) -> the value latched at the accepting edge (0x11) is written.

Source files
------------

// File: rtl/regfile_rr_arbiter.sv
// Two-port register file behind a round-robin arbiter: one access is accepted
// in IDLE, carried out in a single ACCESS cycle, and read data returns one cycle later.
module regfile_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [AW-1:0]    addr0,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   output logic             rsrc
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   state_t           state_q;
   logic             prio_q;
   logic             win_q;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic [WIDTH-1:0] rdata_q;
   logic             rvalid_q;
   logic             rsrc_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             win_d;
   logic             addr_ok;

   // With both requesting, prio decides; otherwise whoever asks wins.
   always_comb begin
      win_d = req1;
      if (req0 && req1) begin
         win_d = prio_q;
      end
   end

   assign addr_ok = ({1'b0, addr_q} < DEPTH_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rsrc_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rvalid_q <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  win_q   <= win_d;
                  prio_q  <= ~win_d;
                  we_q    <= win_d ? we1 : we0;
                  addr_q  <= win_d ? addr1 : addr0;
                  wdata_q <= win_d ? wdata1 : wdata0;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               // Requests are not looked at here; the latched command executes.
               state_q <= IDLE;
               if (we_q) begin
                  if (addr_ok) begin
                     mem_q[addr_q] <= wdata_q;
                  end
               end else begin
                  rdata_q  <= addr_ok ? mem_q[addr_q] : '0;
                  rvalid_q <= 1'b1;
                  rsrc_q   <= win_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign rsrc   = rsrc_q;

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Scoreboard bench for regfile_rr_arbiter: stimulus queues expected grants and
// read results, a negedge monitor pops and compares them as the DUT responds.
module tb_regfile_rr_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [1:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid, rsrc;
   logic [7:0] rdata;

   regfile_rr_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .rsrc(rsrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       src;
      logic       rd;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         passes = 0;
   int         gnt_cnt = 0;
   bit         mon_en = 1'b0;
   logic       rst_seen = 1'b0;
   logic       pend_rd = 1'b0;
   logic       pend_src = 1'b0;
   logic [7:0] pend_data = 8'h00;
   logic [7:0] model_rdata = 8'h00;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_seen) begin
            pend_rd     = 1'b0;
            model_rdata = 8'h00;
         end
         if (pend_rd || rvalid) begin
            chk("rvalid_timing", {31'd0, rvalid}, {31'd0, pend_rd});
            if (pend_rd && rvalid) begin
               chk("rdata", {24'd0, rdata}, {24'd0, pend_data});
               chk("rsrc", {31'd0, rsrc}, {31'd0, pend_src});
               model_rdata = pend_data;
            end
         end else begin
            chk("rdata_hold", {24'd0, rdata}, {24'd0, model_rdata});
         end
         pend_rd = 1'b0;
         if (gnt0 || gnt1) begin
            gnt_cnt++;
            chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("gnt_src", {31'd0, gnt1}, {31'd0, e.src});
               pend_rd   = e.rd;
               pend_src  = e.src;
               pend_data = e.data;
            end
         end
      end
   end

   task automatic push_exp(input bit src, input bit rd, input logic [7:0] d);
      exp_t e;
      e.src  = src;
      e.rd   = rd;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit src, input bit we, input logic [1:0] a, input logic [7:0] d);
      if (src) begin
         we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
      end else begin
         we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
      end
   endtask

   task automatic wait_gnt(input bit src);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(posedge clk); #1;
         seen = src ? gnt1 : gnt0;
      end
      chk(src ? "gnt1_wait" : "gnt0_wait", {31'd0, seen}, 32'd1);
   endtask

   task automatic drop_req(input bit src);
      @(posedge clk); #1;
      if (src) req1 = 1'b0;
      else req0 = 1'b0;
   endtask

   task automatic access(input bit src, input bit we, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
      push_exp(src, ~we, exp_rd);
      drive(src, we, a, d);
      wait_gnt(src);
      drop_req(src);
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 2'd0; addr1 = 2'd0; wdata0 = 8'h00; wdata1 = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_rsrc", {31'd0, rsrc}, 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Storage cleared by reset.
      for (int a = 0; a < 4; a++) access(1'b0, 1'b0, 2'(a), 8'h00, 8'h00);

      // Write through port 0, read back through port 1.
      access(1'b0, 1'b1, 2'd2, 8'hA5, 8'h00);
      access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5);

      // req1 alone twice while prio is 0, then a tie must go to requester 0.
      access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5);
      access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5);
      push_exp(1'b0, 1'b1, 8'h00);
      push_exp(1'b1, 1'b1, 8'hA5);
      drive(1'b0, 1'b0, 2'd3, 8'h00);
      drive(1'b1, 1'b0, 2'd2, 8'h00);
      fork
         begin wait_gnt(1'b0); drop_req(1'b0); end
         begin wait_gnt(1'b1); drop_req(1'b1); end
      join

      // Command is latched at acceptance; later changes are ignored.
      push_exp(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 2'd1, 8'h11);
      wait_gnt(1'b0);
      addr0 = 2'd0; wdata0 = 8'h22;
      drop_req(1'b0);
      access(1'b0, 1'b0, 2'd1, 8'h00, 8'h11);
      access(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);

      // Reset during the write's ACCESS cycle cancels it and clears storage.
      push_exp(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 2'd3, 8'h3C);
      wait_gnt(1'b0);
      rst = 1'b1; req0 = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      access(1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
      access(1'b1, 1'b0, 2'd2, 8'h00, 8'h00);

      // Both requesters held high out of reset: grants alternate 0,1,0,1,0,1.
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      drive(1'b1, 1'b0, 2'd1, 8'h00);
      for (int k = 0; k < 6; k++) push_exp(1'(k % 2), 1'b1, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      begin
         int target;
         bit done;
         target = gnt_cnt + 6;
         done = 1'b0;
         for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            done = (gnt_cnt >= target);
         end
         chk("b2b_wait", {31'd0, done}, 32'd1);
      end
      req0 = 1'b0; req1 = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
